// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the iteration count.
package mdu_pkg;

  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide over the {acc_hi, acc_lo} pair.
module mdu_step (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] acc_hi_next,
  output logic [31:0] acc_lo_next
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] divisor;

  always_comb begin
    sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    rem_sh      = {acc_hi, acc_lo[31]};
    divisor     = {1'b0, operand};
    acc_hi_next = acc_hi;
    acc_lo_next = acc_lo;
    if (is_div) begin
      // Quotient bits shift into acc_lo as dividend bits shift out of it.
      if (rem_sh >= divisor) begin
        acc_hi_next = 32'(rem_sh - divisor);
        acc_lo_next = {acc_lo[30:0], 1'b1};
      end else begin
        acc_hi_next = rem_sh[31:0];
        acc_lo_next = {acc_lo[30:0], 1'b0};
      end
    end else begin
      acc_hi_next = sum[32:1];
      acc_lo_next = {sum[0], acc_lo[31:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32 iterations on magnitudes, then a
// sign-fix cycle that writes HI/LO and pulses done.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

  op_e         op_in;
  logic        in_signed;
  logic        in_sa;
  logic        in_sb;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  logic [63:0] prod_mag;
  logic [63:0] prod_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;
  logic        by_zero;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_sa     = in_signed & a[31];
  assign in_sb     = in_signed & b[31];

  mdu_step u_step (
    .is_div      (op_is_div(op_q)),
    .acc_hi      (acc_hi_q),
    .acc_lo      (acc_lo_q),
    .operand     (opb_q),
    .acc_hi_next (step_hi),
    .acc_lo_next (step_lo)
  );

  // Sign correction of the magnitude results; divide-by-zero keeps the
  // sign-restored dividend as remainder and forces an all-ones quotient.
  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_res = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    by_zero  = (opb_q == 32'd0);
    rem_res  = sign_a_q ? -acc_hi_q : acc_hi_q;
    quo_res  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
    if (by_zero) begin
      quo_res = 32'hFFFF_FFFF;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d     = op_in;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          acc_hi_d = 32'd0;
          acc_lo_d = in_sa ? -a : a;
          opb_d    = in_sb ? -b : b;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_is_div(op_q)) begin
          hi_d   = rem_res;
          lo_d   = quo_res;
          div0_d = by_zero;
        end else begin
          hi_d = prod_res[63:32];
          lo_d = prod_res[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= 5'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, div0, HI/LO
// writes, busy-time ignores and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a start (optionally with HI/LO writes) for exactly one rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic whi, input logic wlo, input logic [31:0] wd);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    hi_we = whi; lo_we = wlo; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Checks busy/done timing from the start edge through done, then results.
  // mode 1: stray start and HI write while busy; mode 2: HI/LO hold hold_val.
  task automatic finish_op(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_div0,
                           input int mode, input logic [31:0] hold_val);
    logic bad_timing;
    bad_timing = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1) bad_timing = 1'b1;
      if (mode == 1) begin
        start = (i == 5);
        if (i == 5) begin op = 2'b11; a = 32'd9; b = 32'd0; end
        hi_we = (i == 8);
        if (i == 8) wdata = 32'hA5A5_A5A5;
        if (i == 10) chk({tag, "_hi_hold_busy"}, hi, hold_val);
      end
      if (mode == 2 && i == 1) begin
        chk({tag, "_hi_wr"}, hi, hold_val);
        chk({tag, "_lo_wr"}, lo, hold_val);
      end
    end
    start = 1'b0; hi_we = 1'b0;
    chk({tag, "_busy_window"}, 32'(bad_timing), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_div0"}, 32'(div0), 32'(exp_div0));
    $display("op %s: hi=%h lo=%h div0=%0b", tag, hi, lo, div0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 32'd0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'd0);
    finish_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
    finish_op("mult_minmin", 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 32'd0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
    finish_op("div_negnum", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 32'd0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
    finish_op("div_negden", 32'd1, 32'hFFFF_FFFD, 1'b0, 0, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    finish_op("div_ovf", 32'd0, 32'h8000_0000, 1'b0, 0, 32'd0);
    issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    finish_op("divu", 32'd2, 32'd14, 1'b0, 0, 32'd0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 32'd0);
    finish_op("div_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 32'd0);

    // Stray start and HI write while busy must be ignored.
    issue(2'b01, 32'h0001_0000, 32'd3, 1'b0, 1'b0, 32'd0);
    finish_op("busy_ign", 32'd0, 32'h0003_0000, 1'b0, 1, 32'hFFFF_FFF9);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    chk("busy_ign_no_second_op", 32'(n_done), 32'd0);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_idle_lo", lo, 32'h0003_0000);
    lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle_lo", lo, 32'h5A5A_5A5A);
    chk("mtlo_idle_hi", hi, 32'hA5A5_A5A5);

    issue(2'b01, 32'd2, 32'd3, 1'b1, 1'b1, 32'h1111_1111);
    finish_op("start_wr", 32'd0, 32'd6, 1'b0, 2, 32'h1111_1111);

    issue(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 32'd0);
    finish_op("divu_zero", 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0, 32'd0);

    // Reset in the middle of RUN clears everything at once.
    issue(2'b01, 32'h0012_3456, 32'h0000_0777, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    issue(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0);
    finish_op("post_rst_multu", 32'd0, 32'd15, 1'b0, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
